// File: rtl/calc_entry_ctrl.sv
// Keypad-entry sequencer for a two-operand BCD calculator.
// Steers digits into operand A/B shift registers, latches the operator,
// launches the ALU on '=' and selects the display source. The operand
// registers have no reset, so a clear shifts MAX_DIGITS zeros into both.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_CLR_ALL  | shifting zeros into A and B, then optional pending digit
// S_ENTER_A  | collecting digits for operand A, display A
// S_ENTER_B  | collecting digits for operand B, display B
// S_WAIT_ALU | ALU launched, keys blocked until alu_done
// S_SHOW_RES | result displayed; a digit starts a new calculation
module calc_entry_ctrl #(
    parameter int MAX_DIGITS = 2,
    parameter int DIG_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_key_valid,
    output logic             o_key_ready,
    input  logic [1:0]       i_key_type,
    input  logic [DIG_W-1:0] i_key_digit,
    input  logic [1:0]       i_key_op,
    input  logic             i_alu_done,
    output logic [DIG_W-1:0] o_shift_data,
    output logic             o_en_a,
    output logic             o_en_b,
    output logic [1:0]       o_op_code,
    output logic             o_alu_start,
    output logic [1:0]       o_disp_sel,
    output logic             o_digit_err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(9);

    localparam logic [1:0] KEY_DIGIT = 2'b00;
    localparam logic [1:0] KEY_OP    = 2'b01;
    localparam logic [1:0] KEY_EQ    = 2'b10;
    localparam logic [1:0] KEY_CLR   = 2'b11;

    localparam logic [1:0] DISP_A   = 2'b00;
    localparam logic [1:0] DISP_B   = 2'b01;
    localparam logic [1:0] DISP_RES = 2'b10;

    typedef enum logic [2:0] {
        S_CLR_ALL  = 3'd0,
        S_ENTER_A  = 3'd1,
        S_ENTER_B  = 3'd2,
        S_WAIT_ALU = 3'd3,
        S_SHOW_RES = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_clr_cnt;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic             r_pending;
    logic [DIG_W-1:0] r_pend_digit;
    logic [DIG_W-1:0] r_shift_data;
    logic             r_en_a;
    logic             r_en_b;
    logic [1:0]       r_op_code;
    logic             r_alu_start;
    logic [1:0]       r_disp_sel;
    logic             r_digit_err;
    logic             r_key_ready;

    state_t           w_state;
    logic [CNT_W-1:0] w_clr_cnt;
    logic [CNT_W-1:0] w_cnt_a;
    logic [CNT_W-1:0] w_cnt_b;
    logic             w_pending;
    logic [DIG_W-1:0] w_pend_digit;
    logic [DIG_W-1:0] w_shift_data;
    logic             w_en_a;
    logic             w_en_b;
    logic [1:0]       w_op_code;
    logic             w_alu_start;
    logic [1:0]       w_disp_sel;
    logic             w_digit_err;
    logic             w_key_ready;
    logic             w_accept;
    logic             w_digit_ok;
    logic             w_go_clear;

    assign w_accept   = i_key_valid & r_key_ready;
    assign w_digit_ok = (i_key_digit <= DIG_MAX);

    // State and all outputs registered; async reset returns everything to idle-clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_CLR_ALL;
            r_clr_cnt    <= '0;
            r_cnt_a      <= '0;
            r_cnt_b      <= '0;
            r_pending    <= 1'b0;
            r_pend_digit <= '0;
            r_shift_data <= '0;
            r_en_a       <= 1'b0;
            r_en_b       <= 1'b0;
            r_op_code    <= 2'b00;
            r_alu_start  <= 1'b0;
            r_disp_sel   <= DISP_A;
            r_digit_err  <= 1'b0;
            r_key_ready  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_clr_cnt    <= w_clr_cnt;
            r_cnt_a      <= w_cnt_a;
            r_cnt_b      <= w_cnt_b;
            r_pending    <= w_pending;
            r_pend_digit <= w_pend_digit;
            r_shift_data <= w_shift_data;
            r_en_a       <= w_en_a;
            r_en_b       <= w_en_b;
            r_op_code    <= w_op_code;
            r_alu_start  <= w_alu_start;
            r_disp_sel   <= w_disp_sel;
            r_digit_err  <= w_digit_err;
            r_key_ready  <= w_key_ready;
        end
    end

    // Next-state and next-output decode; pulses default low, levels hold.
    always_comb begin
        w_state      = r_state;
        w_clr_cnt    = r_clr_cnt;
        w_cnt_a      = r_cnt_a;
        w_cnt_b      = r_cnt_b;
        w_pending    = r_pending;
        w_pend_digit = r_pend_digit;
        w_shift_data = r_shift_data;
        w_en_a       = 1'b0;
        w_en_b       = 1'b0;
        w_op_code    = r_op_code;
        w_alu_start  = 1'b0;
        w_disp_sel   = r_disp_sel;
        w_digit_err  = 1'b0;
        w_key_ready  = r_key_ready;
        w_go_clear   = 1'b0;

        case (r_state)
            S_CLR_ALL: begin
                w_key_ready = 1'b0;
                w_disp_sel  = DISP_A;
                if (r_clr_cnt < CNT_MAX) begin
                    w_en_a       = 1'b1;
                    w_en_b       = 1'b1;
                    w_shift_data = '0;
                    w_clr_cnt    = r_clr_cnt + CNT_ONE;
                    w_cnt_a      = '0;
                    w_cnt_b      = '0;
                end else if (r_pending) begin
                    // Digit typed over a result becomes the first digit of A.
                    w_en_a       = 1'b1;
                    w_shift_data = r_pend_digit;
                    w_cnt_a      = CNT_ONE;
                    w_pending    = 1'b0;
                end else begin
                    w_state     = S_ENTER_A;
                    w_key_ready = 1'b1;
                end
            end

            S_ENTER_A: begin
                if (w_accept) begin
                    case (i_key_type)
                        KEY_DIGIT: begin
                            if (w_digit_ok && (r_cnt_a < CNT_MAX)) begin
                                w_en_a       = 1'b1;
                                w_shift_data = i_key_digit;
                                w_cnt_a      = r_cnt_a + CNT_ONE;
                            end else begin
                                w_digit_err = 1'b1;
                            end
                        end
                        KEY_OP: begin
                            w_op_code  = i_key_op;
                            w_cnt_b    = '0;
                            w_state    = S_ENTER_B;
                            w_disp_sel = DISP_B;
                        end
                        KEY_CLR: w_go_clear = 1'b1;
                        default: ;
                    endcase
                end
            end

            S_ENTER_B: begin
                if (w_accept) begin
                    case (i_key_type)
                        KEY_DIGIT: begin
                            if (w_digit_ok && (r_cnt_b < CNT_MAX)) begin
                                w_en_b       = 1'b1;
                                w_shift_data = i_key_digit;
                                w_cnt_b      = r_cnt_b + CNT_ONE;
                            end else begin
                                w_digit_err = 1'b1;
                            end
                        end
                        KEY_OP: w_op_code = i_key_op;
                        KEY_EQ: begin
                            w_alu_start = 1'b1;
                            w_state     = S_WAIT_ALU;
                            w_key_ready = 1'b0;
                        end
                        KEY_CLR: w_go_clear = 1'b1;
                        default: ;
                    endcase
                end
            end

            S_WAIT_ALU: begin
                w_key_ready = 1'b0;
                if (i_alu_done) begin
                    w_state     = S_SHOW_RES;
                    w_disp_sel  = DISP_RES;
                    w_key_ready = 1'b1;
                end
            end

            S_SHOW_RES: begin
                if (w_accept) begin
                    case (i_key_type)
                        KEY_DIGIT: begin
                            if (w_digit_ok) begin
                                w_go_clear   = 1'b1;
                                w_pend_digit = i_key_digit;
                            end else begin
                                w_digit_err = 1'b1;
                            end
                        end
                        KEY_CLR: w_go_clear = 1'b1;
                        default: ;
                    endcase
                end
            end

            default: begin
                w_state     = S_CLR_ALL;
                w_clr_cnt   = '0;
                w_key_ready = 1'b0;
            end
        endcase

        // Any clear restarts the full zero sequence; only a digit over a result leaves a pending digit.
        if (w_go_clear) begin
            w_state     = S_CLR_ALL;
            w_clr_cnt   = '0;
            w_key_ready = 1'b0;
            w_disp_sel  = DISP_A;
            w_pending   = (r_state == S_SHOW_RES) && (i_key_type == KEY_DIGIT);
        end
    end

    assign o_key_ready  = r_key_ready;
    assign o_shift_data = r_shift_data;
    assign o_en_a       = r_en_a;
    assign o_en_b       = r_en_b;
    assign o_op_code    = r_op_code;
    assign o_alu_start  = r_alu_start;
    assign o_disp_sel   = r_disp_sel;
    assign o_digit_err  = r_digit_err;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: key sequences with hand-computed outputs.
module tb_calc_entry_ctrl;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic       key_ready;
    logic [1:0] key_type;
    logic [3:0] key_digit;
    logic [1:0] key_op;
    logic       alu_done;
    logic [3:0] shift_data;
    logic       en_a;
    logic       en_b;
    logic [1:0] op_code;
    logic       alu_start;
    logic [1:0] disp_sel;
    logic       digit_err;

    int errors = 0;
    int checks = 0;

    calc_entry_ctrl #(.MAX_DIGITS(2), .DIG_W(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_key_valid  (key_valid),
        .o_key_ready  (key_ready),
        .i_key_type   (key_type),
        .i_key_digit  (key_digit),
        .i_key_op     (key_op),
        .i_alu_done   (alu_done),
        .o_shift_data (shift_data),
        .o_en_a       (en_a),
        .o_en_b       (en_b),
        .o_op_code    (op_code),
        .o_alu_start  (alu_start),
        .o_disp_sel   (disp_sel),
        .o_digit_err  (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle key event; returns 1ns after the accepting edge.
    task automatic press(input logic [1:0] t, input logic [3:0] d, input logic [1:0] o);
        key_valid = 1'b1;
        key_type  = t;
        key_digit = d;
        key_op    = o;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {7'd0, key_ready}, 8'd0);
        check({tag, "_en_a"},  {7'd0, en_a},      8'd0);
        check({tag, "_en_b"},  {7'd0, en_b},      8'd0);
        check({tag, "_shift"}, {4'd0, shift_data}, 8'd0);
        check({tag, "_op"},    {6'd0, op_code},   8'd0);
        check({tag, "_start"}, {7'd0, alu_start}, 8'd0);
        check({tag, "_disp"},  {6'd0, disp_sel},  8'd0);
        check({tag, "_err"},   {7'd0, digit_err}, 8'd0);
    endtask

    // Two zero-shift cycles on both enables, then ready in ENTER_A.
    task automatic check_clear_seq(input string tag);
        tick();
        check({tag, "_z1_en"},    {6'd0, en_a, en_b}, 8'h03);
        check({tag, "_z1_shift"}, {4'd0, shift_data}, 8'd0);
        check({tag, "_z1_rdy"},   {7'd0, key_ready},  8'd0);
        tick();
        check({tag, "_z2_en"},    {6'd0, en_a, en_b}, 8'h03);
        check({tag, "_z2_shift"}, {4'd0, shift_data}, 8'd0);
        tick();
        check({tag, "_done_en"},  {6'd0, en_a, en_b}, 8'h00);
        check({tag, "_done_rdy"}, {7'd0, key_ready},  8'd1);
        check({tag, "_done_disp"}, {6'd0, disp_sel},  8'd0);
    endtask

    task automatic check_digit(input string tag, input logic a, input logic b, input logic [3:0] d);
        check({tag, "_en"}, {6'd0, en_a, en_b}, {6'd0, a, b});
        check({tag, "_shift"}, {4'd0, shift_data}, {4'd0, d});
        check({tag, "_err"}, {7'd0, digit_err}, 8'd0);
        tick();
        check({tag, "_off"}, {6'd0, en_a, en_b}, 8'h00);
    endtask

    task automatic check_reject(input string tag);
        check({tag, "_en"}, {6'd0, en_a, en_b}, 8'h00);
        check({tag, "_err"}, {7'd0, digit_err}, 8'd1);
        tick();
        check({tag, "_err_off"}, {7'd0, digit_err}, 8'd0);
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_type  = 2'b00;
        key_digit = 4'd0;
        key_op    = 2'b00;
        alu_done  = 1'b0;
        #3;
        check_reset_vals("rst0");
        tick();
        tick();
        check_reset_vals("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        check_clear_seq("boot");

        // ENTER_A: two digits fill A, third rejected, '=' ignored
        press(2'b00, 4'd4, 2'b00);
        check_digit("a_d4", 1'b1, 1'b0, 4'd4);
        press(2'b00, 4'd7, 2'b00);
        check_digit("a_d7", 1'b1, 1'b0, 4'd7);
        press(2'b00, 4'd1, 2'b00);
        check_reject("a_full");
        press(2'b10, 4'd0, 2'b00);
        check("a_eq_start", {7'd0, alu_start}, 8'd0);
        check("a_eq_disp", {6'd0, disp_sel}, 8'd0);
        check("a_eq_rdy", {7'd0, key_ready}, 8'd1);

        // ENTER_B: operator 10, bad digit, 3, 9, then '='
        press(2'b01, 4'd0, 2'b10);
        check("b_op", {6'd0, op_code}, 8'h02);
        check("b_disp", {6'd0, disp_sel}, 8'h01);
        check("b_op_en", {6'd0, en_a, en_b}, 8'h00);
        press(2'b00, 4'hC, 2'b00);
        check_reject("b_bad");
        press(2'b00, 4'd3, 2'b00);
        check_digit("b_d3", 1'b0, 1'b1, 4'd3);
        press(2'b00, 4'd9, 2'b00);
        check_digit("b_d9", 1'b0, 1'b1, 4'd9);
        press(2'b10, 4'd0, 2'b00);
        check("eq_start", {7'd0, alu_start}, 8'd1);
        check("eq_rdy", {7'd0, key_ready}, 8'd0);
        tick();
        check("eq_start_off", {7'd0, alu_start}, 8'd0);
        check("wait_rdy", {7'd0, key_ready}, 8'd0);
        press(2'b00, 4'd2, 2'b00);
        check("wait_key_en", {6'd0, en_a, en_b}, 8'h00);
        check("wait_disp", {6'd0, disp_sel}, 8'h01);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("res_disp", {6'd0, disp_sel}, 8'h02);
        check("res_rdy", {7'd0, key_ready}, 8'd1);

        // SHOW_RES: '=' ignored, digit 5 clears and seeds A
        press(2'b10, 4'd0, 2'b00);
        check("res_eq_start", {7'd0, alu_start}, 8'd0);
        check("res_eq_disp", {6'd0, disp_sel}, 8'h02);
        press(2'b00, 4'd5, 2'b00);
        check("res_d5_rdy", {7'd0, key_ready}, 8'd0);
        check("res_d5_en", {6'd0, en_a, en_b}, 8'h00);
        tick();
        check("pend_z1", {6'd0, en_a, en_b}, 8'h03);
        check("pend_z1_shift", {4'd0, shift_data}, 8'd0);
        tick();
        check("pend_z2", {6'd0, en_a, en_b}, 8'h03);
        tick();
        check("pend_load_en", {6'd0, en_a, en_b}, 8'h02);
        check("pend_load_shift", {4'd0, shift_data}, 8'd5);
        tick();
        check("pend_done_en", {6'd0, en_a, en_b}, 8'h00);
        check("pend_done_rdy", {7'd0, key_ready}, 8'd1);
        check("pend_done_disp", {6'd0, disp_sel}, 8'd0);
        press(2'b00, 4'd8, 2'b00);
        check_digit("pend_cnt1", 1'b1, 1'b0, 4'd8);
        press(2'b00, 4'd6, 2'b00);
        check_reject("pend_cnt2_full");

        // Clear from ENTER_B after one digit: op retained, counts zero
        press(2'b01, 4'd0, 2'b01);
        check("clr_op", {6'd0, op_code}, 8'h01);
        press(2'b00, 4'd2, 2'b00);
        check_digit("clr_b_d2", 1'b0, 1'b1, 4'd2);
        press(2'b11, 4'd0, 2'b00);
        check("clr_rdy", {7'd0, key_ready}, 8'd0);
        check_clear_seq("clr_b");
        check("clr_op_keep", {6'd0, op_code}, 8'h01);
        press(2'b00, 4'd1, 2'b00);
        check_digit("clr_a1", 1'b1, 1'b0, 4'd1);
        press(2'b00, 4'd2, 2'b00);
        check_digit("clr_a2", 1'b1, 1'b0, 4'd2);
        press(2'b01, 4'd0, 2'b11);
        press(2'b00, 4'd4, 2'b00);
        check_digit("clr_b1", 1'b0, 1'b1, 4'd4);
        press(2'b00, 4'd5, 2'b00);
        check_digit("clr_b2", 1'b0, 1'b1, 4'd5);

        // Reset during second zero-shift cycle
        press(2'b11, 4'd0, 2'b00);
        tick();
        tick();
        check("mid_clr_en", {6'd0, en_a, en_b}, 8'h03);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_clr");
        @(negedge clk);
        rst = 1'b0;
        check_clear_seq("rst_clr_rerun");

        // Reset while waiting on the ALU
        press(2'b01, 4'd0, 2'b11);
        press(2'b10, 4'd0, 2'b00);
        check("wait2_start", {7'd0, alu_start}, 8'd1);
        tick();
        check("wait2_disp", {6'd0, disp_sel}, 8'h01);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_alu");
        @(negedge clk);
        rst = 1'b0;
        check_clear_seq("rst_alu_rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
